// File: rtl/async_oneway_transmitter_pkg.sv
// Shared link definitions for the one-way 6-bit inter-board link.
// Message width, chunking constants, transmitter state encoding and the chunk selector.
package async_oneway_transmitter_pkg;

  localparam int MESSAGE_SIZE  = 16;
  localparam int LINK_CHUNK_W  = 6;
  localparam int LINK_N_CHUNKS = (MESSAGE_SIZE + LINK_CHUNK_W - 1) / LINK_CHUNK_W;
  localparam int LINK_IDX_W    = (LINK_N_CHUNKS > 1) ? $clog2(LINK_N_CHUNKS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP,
    CLOSE
  } link_tx_state_t;

  typedef struct packed {
    logic                    transmit_ctrl;
    logic                    packet_pulse;
    logic [LINK_CHUNK_W-1:0] dout;
  } link_lines_t;

  // Chunk k is msg[6k+5:6k]; the last chunk is zero-padded above the message MSB.
  function automatic logic [LINK_CHUNK_W-1:0] get_chunk(
    input logic [MESSAGE_SIZE-1:0] msg,
    input logic [LINK_IDX_W-1:0]   idx
  );
    logic [LINK_N_CHUNKS-1:0][LINK_CHUNK_W-1:0] chunks;
    chunks = (LINK_N_CHUNKS*LINK_CHUNK_W)'(msg);
    return chunks[idx];
  endfunction

endpackage

// File: rtl/async_oneway_transmitter_hold_timer.sv
// Load/count-down timer shared by every timed transmitter state.
// Loading gives HOLD_CYCLES cycles; expired marks the last of them.
module hold_timer #(
  parameter int HOLD_CYCLES = 8
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic load,
  output logic expired
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)             cnt_d = CW'(HOLD_CYCLES - 1);
    else if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/async_oneway_transmitter.sv
// Sending half of the one-way 6-bit link: serialises a message into held, strobed chunks.
// All link lines come from registers decoded off the next state, so levels change together.
module async_oneway_transmitter
  import async_oneway_transmitter_pkg::*;
#(
  parameter int HOLD_CYCLES = 8
) (
  input  logic                    clk_send,
  input  logic                    rst_n,
  input  logic                    send_req,
  input  logic [MESSAGE_SIZE-1:0] message,
  output logic                    busy,
  output logic                    done,
  output logic                    transmit_ctrl,
  output logic                    packet_pulse,
  output logic [LINK_CHUNK_W-1:0] dout
);

  link_tx_state_t          state_q, state_d;
  logic [MESSAGE_SIZE-1:0] msg_q, msg_d;
  logic [LINK_IDX_W-1:0]   idx_q, idx_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  link_lines_t             lines_q, lines_d;
  logic                    tmr_load, tmr_expired;

  // Every state change restarts the hold period.
  assign tmr_load = (state_d != state_q);

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .gclk    (clk_send),
    .grst_n  (rst_n),
    .load    (tmr_load),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (send_req) begin
        state_d = SETUP;
        msg_d   = message;
        idx_d   = '0;
      end
      SETUP:  if (tmr_expired) state_d = STROBE;
      STROBE: if (tmr_expired) state_d = GAP;
      GAP: if (tmr_expired) begin
        if (idx_q == LINK_IDX_W'(LINK_N_CHUNKS - 1)) state_d = CLOSE;
        else begin
          idx_d   = idx_q + LINK_IDX_W'(1);
          state_d = STROBE;
        end
      end
      // The done pulse is one extra CLOSE cycle, so busy covers it.
      CLOSE: begin
        if (done_q)           state_d = IDLE;
        else if (tmr_expired) done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lines_d               = '0;
    lines_d.transmit_ctrl = (state_d == SETUP) || (state_d == STROBE) || (state_d == GAP);
    lines_d.packet_pulse  = (state_d == STROBE);
    if (state_d == STROBE) lines_d.dout = get_chunk(msg_q, idx_d);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_send or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      msg_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      lines_q <= lines_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign transmit_ctrl = lines_q.transmit_ctrl;
  assign packet_pulse  = lines_q.packet_pulse;
  assign dout          = lines_q.dout;

endmodule
